mcdf_reg_bank: RTL and testbench
================================

// Module: mcdf_reg_bank
// PURPOSE
//   Parametrised MCDF control/status register bank for NUM_CH slave channels.
//   Decodes the 2-bit command bus (read/write) and drives per-channel enable, priority
//   and packet length to the slaves and arbiter. Samples slave FIFO margins and raises
//   a maskable low-margin interrupt. Flags illegal accesses and returns read data with a valid strobe.
// PARAMETERS
//   NUM_CH     3             number of slave channels, 1..8
//   ADDR_W     8             command address width
//   MARGIN_W   8             slave margin width
//   FIFO_DEPTH 64            margin/status reset value (empty FIFO)
//   ID_VAL     32'h4D43_0002 value returned by the ID register
// PORTS
//   clk_i          in   1               clock
//   rstn_i         in   1               asynchronous reset, active-low
//   cmd_i          in   2               00 idle, 01 read, 10 write, 11 reserved
//   cmd_addr_i     in   ADDR_W          byte address
//   cmd_data_i     in   32              write data
//   cmd_data_o     out  32              read data (registered)
//   cmd_rvalid_o   out  1               1-cycle pulse: cmd_data_o updated by a read
//   cmd_err_o      out  1               1-cycle pulse: illegal access
//   slv_margin_i   in   NUM_CH*MARGIN_W channel i at [i*MARGIN_W +: MARGIN_W]
//   slv_en_o       out  NUM_CH          channel enable
//   slv_prio_o     out  NUM_CH*2        channel priority
//   slv_pkglen_o   out  NUM_CH*3        channel packet length code
//   irq_o          out  1               |(IRQ_STAT & IRQ_MASK)
// BEHAVIOUR
//   Address map (addr[1:0] must be 00; channel index i < NUM_CH, else illegal):
//     0x00+4i CTRLi RW {26'b0, pkglen[5:3], prio[2:1], en[0]}; write bits [31:6] ignored.
//     0x20+4i STATi RO {24'b0, margin sampled the previous cycle}.
//     0x40 IRQ_STAT W1C [NUM_CH-1:0]. 0x44 IRQ_MASK RW [NUM_CH-1:0].
//     0x48 THRESH RW [MARGIN_W-1:0]. 0x4C ID RO = ID_VAL.
//   Reset: CTRL=0, STAT margin=FIFO_DEPTH, IRQ_STAT=0, IRQ_MASK=0, THRESH=8.
//     Outputs at reset: cmd_data_o=0, rvalid=0, err=0, irq_o=0.
//   Read (cmd_i=01): cmd_data_o updates at the next edge; rvalid pulses that same cycle.
//     Latency is 1 cycle. cmd_data_o holds its value until the next read.
//   Write (cmd_i=10): the register updates at the edge. A read in the following cycle sees the new value.
//   Illegal access: unmapped address, misaligned address, i>=NUM_CH, write to an RO register, or cmd_i=11.
//     err pulses 1 cycle with no state change. An illegal read also loads cmd_data_o=0 and pulses rvalid.
//   STAT sampling: every cycle, STATi <= slv_margin_i slice i.
//   IRQ: IRQ_STAT[i] sets on any cycle where en[i]=1 and STATi < THRESH (strictly less).
//     Set is sticky. W1C clears the bits written as 1.
//     If set and clear hit the same bit in the same cycle, set wins.
//   irq_o is combinational from flops only (no input paths).
//   Reset asserted mid-access aborts the access; all state returns to reset values.
// CONFIGURATION
//   `MCDF_REG_WMARK_EN defined:
//     adds WMARKi RO at 0x60+4i: minimum STATi since last read (reset FIFO_DEPTH).
//     Each cycle WMARKi <= min(WMARKi, STATi).
//     Reading WMARKi returns the current value and reloads it with STATi; the reload beats the min update.
//   Not defined: no WMARK storage; 0x60+4i decode as illegal (err pulse).
// STRUCTURE
//   Package mcdf_reg_pkg: CMD_IDLE/CMD_RD/CMD_WR encodings.
//     Also CTRL_BASE/STAT_BASE/IRQ_STAT/IRQ_MASK/THRESH/ID/WMARK_BASE offsets.
//     Also CTRL field LSB/width constants and THRESH reset value.
//   Sub-module mcdf_reg_ch: one channel's CTRL, STAT, IRQ set logic and optional WMARK.
//     Instantiated NUM_CH times via generate. Top holds decode, read mux, IRQ_MASK/THRESH and err/rvalid.
// TESTING
//   1 Reset, then read 0x00,0x20,0x4C -> 0, 64, ID_VAL; rvalid pulse 1 cycle after each cmd, err=0.
//   2 Write 0x04=0xFFFF_FFFF, read 0x04 -> 0x3F; slv_en_o[1]=1, prio=3, pkglen=7.
//   3 Write 0x03, write 0x20, read 0x2C with NUM_CH=3, cmd=11 -> err pulse each time.
//     Illegal read returns 0 with rvalid. No register changes.
//   4 CTRL0 en=1, MASK=1, THRESH=8, margin0=7 -> IRQ_STAT[0]=1, irq_o=1.
//     margin0=8 then W1C 0x40=1 -> clears. Margin held at 7 during W1C -> bit stays 1.
//   5 (WMARK_EN) margin0 64->5->30: read 0x60 -> 5; read again -> 30.
//     Without the macro, 0x60 -> err.
//   6 Assert rstn_i the cycle after a write to 0x08 -> CTRL2=0, cmd_data_o=0, irq_o=0 immediately.

Source files
------------

// File: rtl/mcdf_reg_pkg.sv
// Shared command encodings, register offsets and CTRL field layout for the MCDF register bank.
package mcdf_reg_pkg;

   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_RD   = 2'b01;
   localparam logic [1:0] CMD_WR   = 2'b10;
   localparam logic [1:0] CMD_RSVD = 2'b11;

   localparam int unsigned CTRL_BASE  = 'h00;
   localparam int unsigned STAT_BASE  = 'h20;
   localparam int unsigned IRQ_STAT   = 'h40;
   localparam int unsigned IRQ_MASK   = 'h44;
   localparam int unsigned THRESH     = 'h48;
   localparam int unsigned ID         = 'h4C;
   localparam int unsigned WMARK_BASE = 'h60;

   localparam int unsigned CTRL_EN_LSB   = 0;
   localparam int unsigned CTRL_PRIO_LSB = 1;
   localparam int unsigned CTRL_PRIO_W   = 2;
   localparam int unsigned CTRL_LEN_LSB  = 3;
   localparam int unsigned CTRL_LEN_W    = 3;
   localparam int unsigned CTRL_W        = 6;

   localparam int unsigned THRESH_RST = 8;

endpackage

// File: rtl/mcdf_reg_ch.sv
// One MCDF channel: CTRL register, margin sampling, sticky low-margin IRQ bit and,
// when MCDF_REG_WMARK_EN is defined, the minimum-margin watermark.
module mcdf_reg_ch
   import mcdf_reg_pkg::*;
#(
   parameter int unsigned MARGIN_W   = 8,
   parameter int unsigned FIFO_DEPTH = 64
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                ctrl_we_i,
   input  logic [CTRL_W-1:0]   ctrl_wdata_i,
   input  logic                wmark_rd_i,
   input  logic                irq_clr_i,
   input  logic [MARGIN_W-1:0] thresh_i,
   input  logic [MARGIN_W-1:0] margin_i,
   output logic [CTRL_W-1:0]   ctrl_o,
   output logic [MARGIN_W-1:0] stat_o,
   output logic [MARGIN_W-1:0] wmark_o,
   output logic                irq_stat_o
);

   logic [CTRL_W-1:0]   ctrl_q;
   logic [MARGIN_W-1:0] stat_q;
   logic                irq_q, irq_d;

   // Set has priority over a same-cycle W1C clear.
   always_comb begin
      irq_d = irq_q & ~irq_clr_i;
      if (ctrl_q[CTRL_EN_LSB] && (stat_q < thresh_i)) irq_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ctrl_q <= '0;
         stat_q <= MARGIN_W'(FIFO_DEPTH);
         irq_q  <= 1'b0;
      end else begin
         if (ctrl_we_i) ctrl_q <= ctrl_wdata_i;
         stat_q <= margin_i;
         irq_q  <= irq_d;
      end
   end

   assign ctrl_o     = ctrl_q;
   assign stat_o     = stat_q;
   assign irq_stat_o = irq_q;

`ifdef MCDF_REG_WMARK_EN
   logic [MARGIN_W-1:0] wmark_q, wmark_d;

   // A read reloads the watermark, overriding the running minimum.
   always_comb begin
      wmark_d = (stat_q < wmark_q) ? stat_q : wmark_q;
      if (wmark_rd_i) wmark_d = stat_q;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) wmark_q <= MARGIN_W'(FIFO_DEPTH);
      else         wmark_q <= wmark_d;
   end

   assign wmark_o = wmark_q;
`else
   logic unused_wmark_rd;
   assign unused_wmark_rd = wmark_rd_i;
   assign wmark_o         = '0;
`endif

endmodule

// File: rtl/mcdf_reg_bank.sv
// MCDF control/status register bank: command decode, read mux, IRQ mask/threshold, err/rvalid.
// Optional per-channel watermark registers are enabled by defining MCDF_REG_WMARK_EN.
module mcdf_reg_bank
   import mcdf_reg_pkg::*;
#(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned MARGIN_W   = 8,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter logic [31:0] ID_VAL     = 32'h4D43_0002
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [1:0]                   cmd_i,
   input  logic [ADDR_W-1:0]            cmd_addr_i,
   input  logic [31:0]                  cmd_data_i,
   output logic [31:0]                  cmd_data_o,
   output logic                         cmd_rvalid_o,
   output logic                         cmd_err_o,
   input  logic [NUM_CH*MARGIN_W-1:0]   slv_margin_i,
   output logic [NUM_CH-1:0]            slv_en_o,
   output logic [NUM_CH*2-1:0]          slv_prio_o,
   output logic [NUM_CH*3-1:0]          slv_pkglen_o,
   output logic                         irq_o
);

   logic [NUM_CH-1:0]   ctrl_hit, stat_hit, wmark_hit;
   logic                irqs_hit, mask_hit, thresh_hit, id_hit;
   logic                rd, wr, legal_rd, legal_wr, err;
   logic [31:0]         rdata;
   logic [NUM_CH-1:0]   irq_stat, irq_clr, ctrl_we, wmark_rd;
   logic [CTRL_W-1:0]   ctrl  [NUM_CH];
   logic [MARGIN_W-1:0] stat  [NUM_CH];
   logic [MARGIN_W-1:0] wmark [NUM_CH];
   logic [NUM_CH-1:0]   irq_mask_q;
   logic [MARGIN_W-1:0] thresh_q;
   logic [31:0]         data_q;
   logic                rvalid_q, err_q;
   logic                unused_wdata;

   assign rd = (cmd_i == CMD_RD);
   assign wr = (cmd_i == CMD_WR);

   // Exact-address compares also reject misaligned addresses.
   always_comb begin
      ctrl_hit  = '0;
      stat_hit  = '0;
      wmark_hit = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ctrl_hit[i] = (cmd_addr_i == ADDR_W'(CTRL_BASE + 4 * i));
         stat_hit[i] = (cmd_addr_i == ADDR_W'(STAT_BASE + 4 * i));
`ifdef MCDF_REG_WMARK_EN
         wmark_hit[i] = (cmd_addr_i == ADDR_W'(WMARK_BASE + 4 * i));
`endif
      end
   end

   assign irqs_hit   = (cmd_addr_i == ADDR_W'(IRQ_STAT));
   assign mask_hit   = (cmd_addr_i == ADDR_W'(IRQ_MASK));
   assign thresh_hit = (cmd_addr_i == ADDR_W'(THRESH));
   assign id_hit     = (cmd_addr_i == ADDR_W'(ID));

   assign legal_rd = (|ctrl_hit) | (|stat_hit) | (|wmark_hit) | irqs_hit | mask_hit |
                     thresh_hit | id_hit;
   assign legal_wr = (|ctrl_hit) | irqs_hit | mask_hit | thresh_hit;
   assign err      = (cmd_i == CMD_RSVD) | (rd & ~legal_rd) | (wr & ~legal_wr);

   assign ctrl_we  = {NUM_CH{wr}} & ctrl_hit;
   assign wmark_rd = {NUM_CH{rd}} & wmark_hit;
   assign irq_clr  = (wr && irqs_hit) ? cmd_data_i[NUM_CH-1:0] : '0;

   // No hit leaves rdata at zero, which is what an illegal read returns.
   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ctrl_hit[i])  rdata = 32'(ctrl[i]);
         if (stat_hit[i])  rdata = 32'(stat[i]);
         if (wmark_hit[i]) rdata = 32'(wmark[i]);
      end
      if (irqs_hit)   rdata = 32'(irq_stat);
      if (mask_hit)   rdata = 32'(irq_mask_q);
      if (thresh_hit) rdata = 32'(thresh_q);
      if (id_hit)     rdata = ID_VAL;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         irq_mask_q <= '0;
         thresh_q   <= MARGIN_W'(THRESH_RST);
         data_q     <= '0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (wr && mask_hit)   irq_mask_q <= cmd_data_i[NUM_CH-1:0];
         if (wr && thresh_hit) thresh_q   <= cmd_data_i[MARGIN_W-1:0];
         if (rd)               data_q     <= rdata;
         rvalid_q <= rd;
         err_q    <= err;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mcdf_reg_ch #(
         .MARGIN_W   (MARGIN_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_ch (
         .clk_i        (clk_i),
         .rstn_i       (rstn_i),
         .ctrl_we_i    (ctrl_we[i]),
         .ctrl_wdata_i (cmd_data_i[CTRL_W-1:0]),
         .wmark_rd_i   (wmark_rd[i]),
         .irq_clr_i    (irq_clr[i]),
         .thresh_i     (thresh_q),
         .margin_i     (slv_margin_i[i*MARGIN_W +: MARGIN_W]),
         .ctrl_o       (ctrl[i]),
         .stat_o       (stat[i]),
         .wmark_o      (wmark[i]),
         .irq_stat_o   (irq_stat[i])
      );

      assign slv_en_o[i]       = ctrl[i][CTRL_EN_LSB];
      assign slv_prio_o[i*2 +: 2]   = ctrl[i][CTRL_PRIO_LSB +: CTRL_PRIO_W];
      assign slv_pkglen_o[i*3 +: 3] = ctrl[i][CTRL_LEN_LSB +: CTRL_LEN_W];
   end

   assign unused_wdata = ^cmd_data_i;

   assign cmd_data_o   = data_q;
   assign cmd_rvalid_o = rvalid_q;
   assign cmd_err_o    = err_q;
   assign irq_o        = |(irq_stat & irq_mask_q);

endmodule

// File: tb/tb_mcdf_reg_bank.sv
// Randomised self-checking bench for mcdf_reg_bank against a register-map level model.
// Honours MCDF_REG_WMARK_EN in the model the same way the design does.
module tb_mcdf_reg_bank;

   localparam int NCH = 3;
   localparam int MW  = 8;
   localparam logic [31:0] IDV = 32'h4D43_0002;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [1:0]        cmd = 2'b00;
   logic [7:0]        addr = '0;
   logic [31:0]       wdata = '0;
   logic [31:0]       cmd_data_o;
   logic              cmd_rvalid_o, cmd_err_o, irq_o;
   logic [NCH*MW-1:0] slv_margin = '0;
   logic [NCH-1:0]    slv_en_o;
   logic [NCH*2-1:0]  slv_prio_o;
   logic [NCH*3-1:0]  slv_pkglen_o;

   mcdf_reg_bank #(
      .NUM_CH     (NCH),
      .ADDR_W     (8),
      .MARGIN_W   (MW),
      .FIFO_DEPTH (64),
      .ID_VAL     (IDV)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .cmd_i        (cmd),
      .cmd_addr_i   (addr),
      .cmd_data_i   (wdata),
      .cmd_data_o   (cmd_data_o),
      .cmd_rvalid_o (cmd_rvalid_o),
      .cmd_err_o    (cmd_err_o),
      .slv_margin_i (slv_margin),
      .slv_en_o     (slv_en_o),
      .slv_prio_o   (slv_prio_o),
      .slv_pkglen_o (slv_pkglen_o),
      .irq_o        (irq_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, register-map view.
   int unsigned m_ctrl [NCH];
   int unsigned m_stat [NCH];
   int unsigned m_wmark[NCH];
   int unsigned m_irq, m_mask, m_thresh;
   int unsigned mg[NCH];
   int unsigned e_data;
   bit          e_rvalid, e_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_ctrl[i] = 0; m_stat[i] = 64; m_wmark[i] = 64;
      end
      m_irq = 0; m_mask = 0; m_thresh = 8;
      e_data = 0; e_rvalid = 0; e_err = 0;
   endfunction

   function automatic bit reg_read(input int unsigned a, output int unsigned v);
      v = 0;
      if (a % 4 != 0) return 0;
      if (a < 'h20) begin
         if (a / 4 < NCH) begin v = m_ctrl[a / 4]; return 1; end
         return 0;
      end
      if (a >= 'h20 && a < 'h40) begin
         if ((a - 'h20) / 4 < NCH) begin v = m_stat[(a - 'h20) / 4]; return 1; end
         return 0;
      end
`ifdef MCDF_REG_WMARK_EN
      if (a >= 'h60 && a < 'h80) begin
         if ((a - 'h60) / 4 < NCH) begin v = m_wmark[(a - 'h60) / 4]; return 1; end
         return 0;
      end
`endif
      if (a == 'h40) begin v = m_irq;    return 1; end
      if (a == 'h44) begin v = m_mask;   return 1; end
      if (a == 'h48) begin v = m_thresh; return 1; end
      if (a == 'h4C) begin v = IDV;      return 1; end
      return 0;
   endfunction

   function automatic bit wr_legal(input int unsigned a);
      if (a % 4 != 0) return 0;
      if (a < 'h20) return (a / 4 < NCH);
      return (a == 'h40 || a == 'h44 || a == 'h48);
   endfunction

   // Advance the model by one clock edge with the given command applied.
   function automatic void model_step(input int unsigned c, input int unsigned a,
                                      input int unsigned d);
      bit          rd = (c == 1);
      bit          wr = (c == 2);
      bit          legal;
      int unsigned v, nirq, clr;
      legal    = reg_read(a, v);
      e_rvalid = rd;
      if (rd) e_data = legal ? v : 0;
      e_err = (c == 3) || (rd && !legal) || (wr && !wr_legal(a));
      clr  = (wr && a == 'h40) ? d : 0;
      nirq = m_irq & ~clr;
      for (int i = 0; i < NCH; i++) begin
         if ((m_ctrl[i] & 1) != 0 && m_stat[i] < m_thresh) nirq |= (1 << i);
`ifdef MCDF_REG_WMARK_EN
         if (rd && a == 'h60 + 4 * i) m_wmark[i] = m_stat[i];
         else if (m_stat[i] < m_wmark[i]) m_wmark[i] = m_stat[i];
`endif
      end
      if (wr && wr_legal(a)) begin
         if (a < 'h20)   m_ctrl[a / 4] = d & 'h3F;
         if (a == 'h44)  m_mask = d & ((1 << NCH) - 1);
         if (a == 'h48)  m_thresh = d & 'hFF;
      end
      m_irq = nirq & ((1 << NCH) - 1);
      for (int i = 0; i < NCH; i++) m_stat[i] = mg[i];
   endfunction

   task automatic drive_margins();
      for (int i = 0; i < NCH; i++) slv_margin[i*MW +: MW] = MW'(mg[i]);
   endtask

   task automatic check_all();
      int unsigned en = 0, pr = 0, ln = 0;
      for (int i = 0; i < NCH; i++) begin
         en |= (m_ctrl[i] & 1) << i;
         pr |= ((m_ctrl[i] >> 1) & 3) << (2 * i);
         ln |= ((m_ctrl[i] >> 3) & 7) << (3 * i);
      end
      check_eq("rdata",  cmd_data_o, e_data);
      check_eq("rvalid", 32'(cmd_rvalid_o), 32'(e_rvalid));
      check_eq("err",    32'(cmd_err_o), 32'(e_err));
      check_eq("irq",    32'(irq_o), 32'((m_irq & m_mask) != 0));
      check_eq("en",     32'(slv_en_o), en);
      check_eq("prio",   32'(slv_prio_o), pr);
      check_eq("pkglen", 32'(slv_pkglen_o), ln);
   endtask

   // Called #1 after a rising edge: apply one command, clock it, then check.
   task automatic step(input int unsigned c, input int unsigned a, input int unsigned d);
      cmd = 2'(c); addr = 8'(a); wdata = d;
      drive_margins();
      model_step(c, a, d);
      @(posedge clk);
      #1;
      check_all();
   endtask

   int unsigned addrs[16] = '{'h00, 'h04, 'h08, 'h0C, 'h20, 'h24, 'h28, 'h2C,
                              'h40, 'h44, 'h48, 'h4C, 'h60, 'h64, 'h03, 'h50};

   initial begin
      model_reset();
      for (int i = 0; i < NCH; i++) mg[i] = 64;
      drive_margins();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rstn = 1'b1;

      // Reset values and ID.
      step(1, 'h00, 0);
      step(1, 'h20, 0);
      check_eq("t1_stat0", cmd_data_o, 32'd64);
      step(1, 'h4C, 0);
      check_eq("t1_id", cmd_data_o, IDV);
      step(0, 0, 0);

      // CTRL write with high bits ignored.
      step(2, 'h04, 32'hFFFF_FFFF);
      step(1, 'h04, 0);
      check_eq("t2_ctrl1", cmd_data_o, 32'h3F);
      check_eq("t2_en1", 32'(slv_en_o[1]), 32'd1);

      // Illegal accesses.
      step(2, 'h03, 32'h1);
      check_eq("t3_misalign", 32'(cmd_err_o), 32'd1);
      step(2, 'h20, 32'h5);
      step(1, 'h2C, 0);
      check_eq("t3_rd_data", cmd_data_o, 32'd0);
      check_eq("t3_rd_valid", 32'(cmd_rvalid_o), 32'd1);
      step(3, 'h00, 32'h3F);
      check_eq("t3_rsvd", 32'(cmd_err_o), 32'd1);

      // Low-margin IRQ, W1C and set-beats-clear.
      step(2, 'h00, 32'h1);
      step(2, 'h44, 32'h1);
      mg[0] = 7;
      step(0, 0, 0);
      step(0, 0, 0);
      check_eq("t4_irq_set", 32'(irq_o), 32'd1);
      mg[0] = 8;
      step(0, 0, 0);
      step(2, 'h40, 32'h1);
      check_eq("t4_irq_clr", 32'(irq_o), 32'd0);
      mg[0] = 7;
      step(0, 0, 0);
      step(2, 'h40, 32'h1);
      check_eq("t4_set_wins", 32'(irq_o), 32'd1);

      // Watermark.
      mg[0] = 64; step(0, 0, 0);
      mg[0] = 5;  step(0, 0, 0); step(0, 0, 0);
      mg[0] = 30; step(0, 0, 0); step(0, 0, 0);
      step(1, 'h60, 0);
`ifdef MCDF_REG_WMARK_EN
      check_eq("t5_wmark_min", cmd_data_o, 32'd5);
      step(1, 'h60, 0);
      check_eq("t5_wmark_reload", cmd_data_o, 32'd30);
`else
      check_eq("t5_wmark_err", 32'(cmd_err_o), 32'd1);
`endif

      // Asynchronous reset right after a write, with a read in flight.
      mg[0] = 7;
      step(1, 'h4C, 0);
      step(2, 'h08, 32'h3F);
      cmd = 2'b01; addr = 8'h08;
      rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      check_eq("t6_ctrl2_en", 32'(slv_en_o[2]), 32'd0);
      @(posedge clk);
      #1;
      cmd = 2'b00;
      rstn = 1'b1;

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         int unsigned c, a, d, r;
         r = $urandom_range(0, 9);
         c = (r < 3) ? 1 : (r < 6) ? 2 : (r == 6) ? 3 : 0;
         a = addrs[$urandom_range(0, 15)];
         d = $urandom;
         if (a == 'h48 && ($urandom_range(0, 1) == 1)) d = $urandom_range(0, 40);
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(0, 3) == 0)
               mg[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(0, 255);
         step(c, a, d);
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
